// File: rtl/kf8253_pkg.sv
// Shared definitions for the 8253 PIT bus initiator: register map, RL field
// encodings, bus-cycle state encoding and the control-word packer.
package kf8253_pkg;

  localparam logic [1:0] ADDR_COUNTER0 = 2'd0;
  localparam logic [1:0] ADDR_COUNTER1 = 2'd1;
  localparam logic [1:0] ADDR_COUNTER2 = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam logic [1:0] RL_LATCH = 2'b00;
  localparam logic [1:0] RL_LSB   = 2'b01;
  localparam logic [1:0] RL_MSB   = 2'b10;
  localparam logic [1:0] RL_BOTH  = 2'b11;

  // Width of the per-phase down-counter; phase lengths must fit in it.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_STROBE,
    BUS_HOLD
  } bus_state_t;

  // Which byte of a transaction is currently on the bus.
  typedef enum logic [1:0] {
    BYTE_SINGLE,
    BYTE_CTRL,
    BYTE_LSB,
    BYTE_MSB
  } byte_sel_t;

  // PIT control word layout: SC1 SC0 RL1 RL0 M2 M1 M0 BCD.
  function automatic logic [7:0] pack_ctrl_word(input logic [1:0] sc,
                                                input logic [1:0] rw,
                                                input logic [2:0] mode,
                                                input logic       bcd);
    return {sc, rw, mode, bcd};
  endfunction

endpackage

// File: rtl/kf8253_bus_initiator_if.sv
// CPU-side pin bundle of the 8253 PIT. The initiator is the master; the PIT
// (or a bench model of it) is the slave and returns read data.
interface kf8253_bus_initiator_if;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic [1:0] address;
  logic [7:0] data_bus_out;
  logic       data_bus_out_en;
  logic [7:0] data_bus_in;

  modport master (
    output chip_select_n, read_enable_n, write_enable_n,
           address, data_bus_out, data_bus_out_en,
    input  data_bus_in
  );

  modport slave (
    input  chip_select_n, read_enable_n, write_enable_n,
           address, data_bus_out, data_bus_out_en,
    output data_bus_in
  );
endinterface

// File: rtl/kf8253_bus_cycle.sv
// Single-byte PIT bus cycle engine. A start in IDLE, or in the final HOLD
// clock, launches a new byte; the latter chains bytes with CS held low.
//
//   state      | meaning
//   BUS_IDLE   | no cycle in flight, all strobes inactive
//   BUS_SETUP  | CS low, address (and write data) valid, strobe still high
//   BUS_STROBE | RD_n or WR_n low; read data is sampled on the final clock
//   BUS_HOLD   | strobe released, CS/address/data held steady
module kf8253_bus_cycle
  import kf8253_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       start_write,
  input  logic [1:0] start_address,
  input  logic [7:0] start_wdata,
  output logic       last,
  output logic       sample_rd,
  kf8253_bus_initiator_if.master pit
);

  localparam logic [CNT_W-1:0] SETUP_LEN  = CNT_W'(SETUP_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_LEN = CNT_W'(STROBE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LEN   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             oe_q, oe_d;
  logic             tc;
  logic             load;

  assign tc = (cnt_q == CNT_ONE);

  // Phase sequencing; pin values are computed from the next state so every pin is a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last      = 1'b0;
    sample_rd = 1'b0;
    load      = 1'b0;

    case (state_q)
      BUS_IDLE: load = start;
      BUS_SETUP: begin
        if (tc) begin
          state_d = BUS_STROBE;
          cnt_d   = STROBE_LEN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BUS_STROBE: begin
        sample_rd = tc & ~write_q;
        if (tc) begin
          state_d = BUS_HOLD;
          cnt_d   = HOLD_LEN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      BUS_HOLD: begin
        last = tc;
        if (tc) begin
          if (start) load = 1'b1;
          else       state_d = BUS_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = BUS_IDLE;
    endcase

    if (load) begin
      state_d = BUS_SETUP;
      cnt_d   = SETUP_LEN;
      write_d = start_write;
      addr_d  = start_address;
      wdata_d = start_wdata;
    end

    cs_n_d = (state_d == BUS_IDLE);
    wr_n_d = ~((state_d == BUS_STROBE) & write_d);
    rd_n_d = ~((state_d == BUS_STROBE) & ~write_d);
    oe_d   = (state_d != BUS_IDLE) & write_d;
  end

  // State, phase counter, captured byte and registered pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BUS_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= 2'd0;
      wdata_q <= 8'h00;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
    end
  end

  assign pit.chip_select_n   = cs_n_q;
  assign pit.read_enable_n   = rd_n_q;
  assign pit.write_enable_n  = wr_n_q;
  assign pit.address         = addr_q;
  assign pit.data_bus_out    = wdata_q;
  assign pit.data_bus_out_en = oe_q;

endmodule

// File: rtl/kf8253_bus_initiator.sv
// 8253 PIT bus initiator: accepts single register accesses or a program-counter
// macro (control word, then LSB/MSB count bytes) and drives the PIT CPU port.
module kf8253_bus_initiator
  import kf8253_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_address,
  input  logic [7:0]  cmd_wdata,
  input  logic        prog_valid,
  input  logic [1:0]  prog_counter,
  input  logic [1:0]  prog_rw,
  input  logic [2:0]  prog_mode,
  input  logic        prog_bcd,
  input  logic [15:0] prog_count,
  output logic        prog_error,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  kf8253_bus_initiator_if.master pit
);

  logic        busy_q, busy_d;
  byte_sel_t   byte_sel_q, byte_sel_d;
  logic [1:0]  rw_q, rw_d;
  logic [1:0]  cnt_addr_q, cnt_addr_d;
  logic [15:0] count_q, count_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        prog_error_q, prog_error_d;

  logic        start;
  logic        start_write;
  logic [1:0]  start_address;
  logic [7:0]  start_wdata;
  logic        cyc_last;
  logic        cyc_sample_rd;
  logic        has_next;
  byte_sel_t   next_sel;

  kf8253_bus_cycle #(
    .SETUP_CYCLES  (SETUP_CYCLES),
    .STROBE_CYCLES (STROBE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES)
  ) u_bus_cycle (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .start_write   (start_write),
    .start_address (start_address),
    .start_wdata   (start_wdata),
    .last          (cyc_last),
    .sample_rd     (cyc_sample_rd),
    .pit           (pit)
  );

  // Arbitration (prog wins), byte sequencing and completion/error reporting.
  always_comb begin
    busy_d        = busy_q;
    byte_sel_d    = byte_sel_q;
    rw_d          = rw_q;
    cnt_addr_d    = cnt_addr_q;
    count_d       = count_q;
    rsp_valid_d   = 1'b0;
    prog_error_d  = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    start         = 1'b0;
    start_write   = 1'b0;
    start_address = ADDR_CTRL;
    start_wdata   = 8'h00;
    has_next      = 1'b0;
    next_sel      = BYTE_SINGLE;

    if (!busy_q) begin
      if (prog_valid) begin
        // Counter select 3 would address the read-back/control slot; drop it.
        if (prog_counter == ADDR_CTRL) begin
          prog_error_d = 1'b1;
        end else begin
          start         = 1'b1;
          start_write   = 1'b1;
          start_address = ADDR_CTRL;
          start_wdata   = pack_ctrl_word(prog_counter, prog_rw, prog_mode, prog_bcd);
          busy_d        = 1'b1;
          byte_sel_d    = BYTE_CTRL;
          rw_d          = prog_rw;
          cnt_addr_d    = prog_counter;
          count_d       = prog_count;
        end
      end else if (cmd_valid) begin
        start         = 1'b1;
        start_write   = cmd_write;
        start_address = cmd_address;
        start_wdata   = cmd_wdata;
        busy_d        = 1'b1;
        byte_sel_d    = BYTE_SINGLE;
      end
    end else if (cyc_last) begin
      case (byte_sel_q)
        BYTE_CTRL: begin
          if (rw_q == RL_MSB) begin
            has_next = 1'b1;
            next_sel = BYTE_MSB;
          end else if (rw_q != RL_LATCH) begin
            has_next = 1'b1;
            next_sel = BYTE_LSB;
          end
        end
        BYTE_LSB: begin
          if (rw_q == RL_BOTH) begin
            has_next = 1'b1;
            next_sel = BYTE_MSB;
          end
        end
        default: ;
      endcase

      if (has_next) begin
        start         = 1'b1;
        start_write   = 1'b1;
        start_address = cnt_addr_q;
        start_wdata   = (next_sel == BYTE_MSB) ? count_q[15:8] : count_q[7:0];
        byte_sel_d    = next_sel;
      end else begin
        busy_d      = 1'b0;
        rsp_valid_d = 1'b1;
      end
    end

    if (cyc_sample_rd) rsp_rdata_d = pit.data_bus_in;
  end

  // Sequencer and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q       <= 1'b0;
      byte_sel_q   <= BYTE_SINGLE;
      rw_q         <= RL_LATCH;
      cnt_addr_q   <= 2'd0;
      count_q      <= 16'h0000;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      prog_error_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      byte_sel_q   <= byte_sel_d;
      rw_q         <= rw_d;
      cnt_addr_q   <= cnt_addr_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      prog_error_q <= prog_error_d;
    end
  end

  assign cmd_ready  = ~busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign prog_error = prog_error_q;

endmodule
